// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte sources, one frame at a time.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned GAP_CLKS = 0,
    localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Req_Done,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic [IDX_W-1:0]     o_Grant_Idx
);
    localparam int unsigned GAP_W = 8;

    typedef enum logic [2:0] {
        s_IDLE        = 3'd0,
        s_LAUNCH      = 3'd1,
        s_WAIT_ACTIVE = 3'd2,
        s_WAIT_DONE   = 3'd3,
        s_GAP         = 3'd4
    } state_t;

    state_t             r_State, w_State_Next;
    logic [IDX_W-1:0]   r_Grant, w_Grant_Next;
    logic [IDX_W-1:0]   w_Win_Idx, w_Base;
    logic [7:0]         r_Tx_Byte, w_Tx_Byte_Next;
    logic               r_Tx_DV, w_Tx_DV_Next;
    logic [NUM_REQ-1:0] r_Ack, w_Ack_Next;
    logic [NUM_REQ-1:0] r_Done, w_Done_Next;
    logic               r_Busy;
    logic [GAP_W-1:0]   r_Gap_Cnt, w_Gap_Cnt_Next;
    logic [7:0]         w_Bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign w_Bytes[g] = i_Req_Byte[8*g +: 8];
    end

`ifdef UART_TX_ARB_FIXED_PRI_EN
    assign w_Base = '0;
`else
    // Search start; advances past the requester whose frame just completed.
    logic [IDX_W-1:0] r_Ptr;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Ptr <= '0;
        end else if (r_State == s_WAIT_DONE && i_Tx_Done) begin
            r_Ptr <= (r_Grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_Grant + IDX_W'(1);
        end
    end

    assign w_Base = r_Ptr;
`endif

    // Scan furthest-first so the requester nearest w_Base overwrites last and wins.
    always_comb begin : p_pick
        int unsigned v_j;
        w_Win_Idx = '0;
        v_j       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            v_j = 32'(w_Base) + (NUM_REQ - 1 - i);
            if (v_j >= NUM_REQ) begin
                v_j = v_j - NUM_REQ;
            end
            if (i_Req_DV[IDX_W'(v_j)]) begin
                w_Win_Idx = IDX_W'(v_j);
            end
        end
    end

    always_comb begin
        w_State_Next   = r_State;
        w_Grant_Next   = r_Grant;
        w_Tx_Byte_Next = r_Tx_Byte;
        w_Tx_DV_Next   = 1'b0;
        w_Ack_Next     = '0;
        w_Done_Next    = '0;
        w_Gap_Cnt_Next = r_Gap_Cnt;
        case (r_State)
            s_IDLE: begin
                if (|i_Req_DV && !i_Tx_Active && !i_Tx_Done) begin
                    w_Grant_Next   = w_Win_Idx;
                    w_Tx_Byte_Next = w_Bytes[w_Win_Idx];
                    w_State_Next   = s_LAUNCH;
                end
            end
            s_LAUNCH: begin
                w_Tx_DV_Next = 1'b1;
                w_Ack_Next   = NUM_REQ'(1) << r_Grant;
                w_State_Next = s_WAIT_ACTIVE;
            end
            s_WAIT_ACTIVE: begin
                if (i_Tx_Active) begin
                    w_State_Next = s_WAIT_DONE;
                end
            end
            s_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    w_Done_Next    = NUM_REQ'(1) << r_Grant;
                    w_Gap_Cnt_Next = '0;
                    w_State_Next   = s_GAP;
                end
            end
            s_GAP: begin
                // Done must also be low so the transmitter is idle before the next DV.
                if (r_Gap_Cnt < GAP_W'(GAP_CLKS)) begin
                    w_Gap_Cnt_Next = r_Gap_Cnt + GAP_W'(1);
                end else if (!i_Tx_Done) begin
                    w_State_Next = s_IDLE;
                end
            end
            default: begin
                w_State_Next = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State   <= s_IDLE;
            r_Grant   <= '0;
            r_Tx_Byte <= 8'h00;
            r_Tx_DV   <= 1'b0;
            r_Ack     <= '0;
            r_Done    <= '0;
            r_Busy    <= 1'b0;
            r_Gap_Cnt <= '0;
        end else begin
            r_State   <= w_State_Next;
            r_Grant   <= w_Grant_Next;
            r_Tx_Byte <= w_Tx_Byte_Next;
            r_Tx_DV   <= w_Tx_DV_Next;
            r_Ack     <= w_Ack_Next;
            r_Done    <= w_Done_Next;
            r_Busy    <= (w_State_Next != s_IDLE);
            r_Gap_Cnt <= w_Gap_Cnt_Next;
        end
    end

    assign o_Req_Ack   = r_Ack;
    assign o_Req_Done  = r_Done;
    assign o_Tx_DV     = r_Tx_DV;
    assign o_Tx_Byte   = r_Tx_Byte;
    assign o_Busy      = r_Busy;
    assign o_Grant_Idx = r_Grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx (4 clocks/bit, 40-clock frame).
module tb_uart_tx_arbiter;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned GAP_CLKS = 5;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic [3:0]  i_Req_DV;
    logic [31:0] i_Req_Byte;
    logic [3:0]  o_Req_Ack;
    logic [3:0]  o_Req_Done;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic        o_Busy;
    logic [1:0]  o_Grant_Idx;

    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_dcnt   = 1'b0;
    logic        stub     = 1'b0;
    logic [5:0]  m_cnt    = 6'd0;
    logic [9:0]  m_frame  = 10'h3FF;
    logic        m_line;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_cnt[4];
    int          done_cnt[4];
    int          dv_cnt = 0;
    int          dv_while_tx = 0;
    int          last_done_cyc = 0;
    logic [7:0]  launch_q[$];
    int          gap_q[$];
    logic [9:0]  cap = 10'd0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS)) dut (
        .i_Clock    (clk),
        .i_Reset    (i_Reset),
        .i_Req_DV   (i_Req_DV),
        .i_Req_Byte (i_Req_Byte),
        .o_Req_Ack  (o_Req_Ack),
        .o_Req_Done (o_Req_Done),
        .o_Tx_DV    (o_Tx_DV),
        .o_Tx_Byte  (o_Tx_Byte),
        .i_Tx_Active(m_active),
        .i_Tx_Done  (m_done),
        .o_Busy     (o_Busy),
        .o_Grant_Idx(o_Grant_Idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: start, 8 data LSB first, stop; Done high 2 clocks; no reset.
    assign m_line = m_active ? m_frame[m_cnt[5:2]] : 1'b1;

    always @(posedge clk) begin
        if (m_active) begin
            if (m_cnt == 6'd39) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_dcnt   <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 6'd1;
            end
        end else if (m_done) begin
            if (m_dcnt) m_done <= 1'b0;
            else        m_dcnt <= 1'b1;
        end
        if (o_Tx_DV && !stub) begin
            m_active <= 1'b1;
            m_cnt    <= 6'd0;
            m_frame  <= {1'b1, o_Tx_Byte, 1'b0};
        end
    end

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (o_Req_Ack[2'(n)]) ack_cnt[n]++;
            if (o_Req_Done[2'(n)]) begin
                done_cnt[n]++;
                last_done_cyc = cyc;
            end
        end
        if (o_Tx_DV) begin
            dv_cnt++;
            launch_q.push_back(o_Tx_Byte);
            gap_q.push_back(cyc - last_done_cyc);
            if (m_active || m_done) dv_while_tx++;
        end
        if (m_active && m_cnt[1:0] == 2'd1) cap[m_cnt[5:2]] = m_line;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; requesters drop DV once their ack has been seen.
    task automatic tick();
        @(negedge clk);
        #1;
        i_Req_DV = i_Req_DV & ~o_Req_Ack;
    endtask

    task automatic set_req(input int n, input logic [7:0] b);
        i_Req_Byte = (i_Req_Byte & ~(32'hFF << (8 * n))) | ({24'd0, b} << (8 * n));
        i_Req_DV   = i_Req_DV | (4'b0001 << n);
    endtask

    task automatic wait_done(input int n, input int target, input int budget, input string tag);
        int k = 0;
        while (done_cnt[n] < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(done_cnt[n] >= target), 32'd1);
    endtask

    task automatic wait_ack(input int n, input int target, input int budget, input string tag);
        int k = 0;
        while (ack_cnt[n] < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(ack_cnt[n] >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((o_Busy || m_active || m_done) && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(o_Busy | m_active | m_done), 32'd0);
    endtask

    initial begin
        int s;
        int a[4];
        int d[4];
        int dv0;
        int dw0;

        i_Reset    = 1'b1;
        i_Req_DV   = 4'd0;
        i_Req_Byte = 32'd0;
        repeat (3) tick();
        chk("rst_tx_dv",   32'(o_Tx_DV),     32'd0);
        chk("rst_tx_byte", 32'(o_Tx_Byte),   32'h00);
        chk("rst_ack",     32'(o_Req_Ack),   32'd0);
        chk("rst_done",    32'(o_Req_Done),  32'd0);
        chk("rst_busy",    32'(o_Busy),      32'd0);
        chk("rst_grant",   32'(o_Grant_Idx), 32'd0);
        i_Reset = 1'b0;
        tick();

        // Single request from requester 2
        set_req(2, 8'hA5);
        tick();
        chk("t1_dv_not_yet", 32'(o_Tx_DV), 32'd0);
        tick();
        chk("t1_tx_dv",   32'(o_Tx_DV),   32'd1);
        chk("t1_ack",     32'(o_Req_Ack), 32'h4);
        chk("t1_byte",    32'(o_Tx_Byte), 32'hA5);
        chk("t1_busy",    32'(o_Busy),    32'd1);
        wait_done(2, 1, 100, "t1_done_timeout");
        repeat (5) tick();
        chk("t1_done_once", 32'(done_cnt[2]), 32'd1);
        chk("t1_ack_once",  32'(ack_cnt[2]),  32'd1);
        chk("t1_no_other_ack", 32'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3]), 32'd0);
        chk("t1_serial",    32'(cap), 32'h34A);
        chk("t1_grant",     32'(o_Grant_Idx), 32'd2);

        // All four together from pointer 0, gap of 5 between frames
        wait_idle("t2_idle");
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        s = launch_q.size();
        a = ack_cnt;
        d = done_cnt;
        set_req(0, 8'h11);
        set_req(1, 8'h22);
        set_req(2, 8'h33);
        set_req(3, 8'h44);
        wait_done(3, d[3] + 1, 400, "t2_done_timeout");
        repeat (5) tick();
        chk("t2_launches", 32'(launch_q.size() - s), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_order%0d", i), 32'(launch_q[s + i]), 32'(8'h11 * (i + 1)));
        end
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_gap%0d", i), 32'(gap_q[s + i]), 32'd8);
        end
        chk("t2_acks",  32'((ack_cnt[0] - a[0]) + (ack_cnt[1] - a[1]) + (ack_cnt[2] - a[2]) + (ack_cnt[3] - a[3])), 32'd4);
        chk("t2_dones", 32'((done_cnt[0] - d[0]) + (done_cnt[1] - d[1]) + (done_cnt[2] - d[2]) + (done_cnt[3] - d[3])), 32'd4);

        // Pointer back at 0: requesters 1 and 3 together, 1 goes first
        wait_idle("t3_idle");
        s = launch_q.size();
        d = done_cnt;
        set_req(1, 8'hB1);
        set_req(3, 8'hB3);
        wait_done(3, d[3] + 1, 200, "t3_done_timeout");
        chk("t3_first",  32'(launch_q[s]),     32'hB1);
        chk("t3_second", 32'(launch_q[s + 1]), 32'hB3);

        // Requester 1 withdraws while 3 waits behind a frame from 0
        wait_idle("t4_idle");
        s = launch_q.size();
        a = ack_cnt;
        d = done_cnt;
        set_req(0, 8'h55);
        wait_ack(0, a[0] + 1, 10, "t4_ack0_timeout");
        set_req(1, 8'h66);
        set_req(3, 8'h77);
        repeat (10) tick();
        i_Req_DV[1] = 1'b0;
        wait_done(3, d[3] + 1, 200, "t4_done_timeout");
        repeat (3) tick();
        chk("t4_no_ack1",  32'(ack_cnt[1] - a[1]), 32'd0);
        chk("t4_ack3",     32'(ack_cnt[3] - a[3]), 32'd1);
        chk("t4_launches", 32'(launch_q.size() - s), 32'd2);
        chk("t4_byte3",    32'(launch_q[s + 1]), 32'h77);

        // Reset 10 clocks into a frame with requester 0 requesting again
        wait_idle("t5_idle");
        a = ack_cnt;
        set_req(0, 8'h0F);
        wait_ack(0, a[0] + 1, 10, "t5_ack_timeout");
        repeat (10) tick();
        set_req(0, 8'hF0);
        tick();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("t5_rst_dv",    32'(o_Tx_DV),     32'd0);
        chk("t5_rst_busy",  32'(o_Busy),      32'd0);
        chk("t5_rst_byte",  32'(o_Tx_Byte),   32'h00);
        chk("t5_rst_grant", 32'(o_Grant_Idx), 32'd0);
        s   = launch_q.size();
        d   = done_cnt;
        dw0 = dv_while_tx;
        wait_done(0, d[0] + 1, 200, "t5_done_timeout");
        repeat (3) tick();
        chk("t5_dv_during_tx", 32'(dv_while_tx - dw0), 32'd0);
        chk("t5_done_once",    32'(done_cnt[0] - d[0]), 32'd1);
        chk("t5_launches",     32'(launch_q.size() - s), 32'd1);
        chk("t5_byte",         32'(launch_q[s]), 32'hF0);

        // Transmitter never goes active: arbiter parks in s_WAIT_ACTIVE
        wait_idle("t6_idle");
        stub = 1'b1;
        a    = ack_cnt;
        dv0  = dv_cnt;
        set_req(2, 8'h3C);
        repeat (25) tick();
        chk("t6_ack_once", 32'(ack_cnt[2] - a[2]), 32'd1);
        chk("t6_dv_once",  32'(dv_cnt - dv0),      32'd1);
        chk("t6_busy",     32'(o_Busy),            32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NUM_REQ` byte requesters. It selects a winner by round-robin, or by fixed priority when so configured, and drives the transmitter's `i_Tx_DV`/`i_Tx_Byte`. It watches `o_Tx_Active`/`o_Tx_Done` to sequence one frame at a time. Per-requester accept and done pulses tell each source when its byte left and when its stop bit finished.

## Interface
- `NUM_REQ`, 4, number of requesters, 2..8.
- `GAP_CLKS`, 0, extra idle clocks inserted between frames, 0..255.
- `IDX_W` (localparam) = `$clog2(NUM_REQ)`.

Ports:
- `i_Clock`  in  1  single clock; all logic on posedge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Req_DV`  in  NUM_REQ  per-requester byte valid; held until ack.
- `i_Req_Byte`  in  8*NUM_REQ  requester n byte at [8n+7:8n]; stable while DV high.
- `o_Req_Ack`  out  NUM_REQ  one-cycle pulse: byte of requester n handed to transmitter.
- `o_Req_Done`  out  NUM_REQ  one-cycle pulse: frame of requester n completed.
- `o_Tx_DV`  out  1  to `uart_tx` `i_Tx_DV`; one-cycle pulse.
- `o_Tx_Byte`  out  8  to `uart_tx` `i_Tx_Byte`; registered, held until next launch.
- `i_Tx_Active`  in  1  from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx` `o_Tx_Done`.
- `o_Busy`  out  1  high in every state except s_IDLE.
- `o_Grant_Idx`  out  IDX_W  index of the current or last granted requester.

## Operation
- States: s_IDLE, s_LAUNCH, s_WAIT_ACTIVE, s_WAIT_DONE, s_GAP. Any undefined encoding goes to s_IDLE.
- s_IDLE: when `|i_Req_DV` and `i_Tx_Active==0` and `i_Tx_Done==0`:
  - pick the winner;
  - register `o_Grant_Idx`, and register `o_Tx_Byte` from the winner's slice;
  - go to s_LAUNCH.
- s_LAUNCH, exactly one cycle:
  - `o_Tx_DV=1` and `o_Req_Ack[grant]=1`;
  - go to s_WAIT_ACTIVE.
- s_WAIT_ACTIVE: on `i_Tx_Active==1`, go to s_WAIT_DONE.
- s_WAIT_DONE: on `i_Tx_Done==1`:
  - pulse `o_Req_Done[grant]`;
  - set round-robin pointer to (grant+1) mod NUM_REQ;
  - clear the 8-bit gap counter;
  - go to s_GAP.
- s_GAP:
  - increment the counter while it is below `GAP_CLKS`;
  - when counter==`GAP_CLKS` and `i_Tx_Done==0`, go to s_IDLE.
  - Waiting for Done low guarantees the transmitter has returned to its idle state before the next DV.
- Round-robin selection: the first asserted `i_Req_DV[n]` searching from pointer upward, wrapping at NUM_REQ-1 to 0. The pointer advances only on completion, never on ack.
- Requesters may withdraw by dropping DV before ack. A byte is committed once ack pulses.
- Requester protocol: drop DV no later than the cycle after ack. DV still high in s_IDLE counts as a new request.
- The winner is chosen only in s_IDLE. Requests arriving in other states wait and are not lost while DV is held.

## Timing
- Reset values:
  - state s_IDLE, pointer 0, `o_Grant_Idx` 0;
  - `o_Tx_DV` 0, `o_Tx_Byte` 8'h00;
  - `o_Req_Ack` 0, `o_Req_Done` 0, `o_Busy` 0.
- Request latency: DV sampled in s_IDLE at edge k, then `o_Tx_DV`/ack high during cycle k+1 to k+2 (after edge k+1).
- `i_Tx_Active` is expected high the cycle after `o_Tx_DV`.
- `o_Req_Done` pulses the cycle after the first sampled `i_Tx_Done==1`. It is exactly one cycle, although `i_Tx_Done` stays high for 2 cycles.
- Back-to-back spacing: the next `o_Tx_DV` comes no earlier than `GAP_CLKS`+2 cycles after entering s_GAP.
- Reset mid-frame:
  - the arbiter returns to s_IDLE; no done pulse is issued for the aborted grant;
  - `uart_tx` has no reset, so the s_IDLE launch guard (Active==0 and Done==0) blocks a new launch until the in-flight frame ends.
- Simultaneous reset and request: reset wins.

## Configuration
- `UART_TX_ARB_FIXED_PRI_EN` defined: fixed priority; the lowest asserted index always wins; the pointer logic is removed.
- `UART_TX_ARB_FIXED_PRI_EN` undefined (default): round-robin as above.

## Test plan
Bench uses `uart_tx` with `CLKS_PER_BIT=4`, so a frame is 40 clocks.

- Single request: requester 2 sends 8'hA5 → one ack[2]; serial line 0,1,0,1,0,0,1,0,1,1 (LSB first) at 4 clocks/bit; done[2] pulses once.
- All four request together, bytes 8'h11/22/33/44 (pointer 0) → serial order 11,22,33,44; pointer ends at 0. With the fixed-priority macro, requester 0 re-requesting immediately starves 3.
- `GAP_CLKS=5` with two queued requests → at least 7 clocks from the done pulse to the next `o_Tx_DV`; line high throughout the gap.
- Requester 1 drops DV before ack while requester 3 is waiting → only ack[3]; no ack[1].
- `i_Reset` pulsed 10 clocks into a frame with requester 0 still requesting → outputs at reset values; no `o_Tx_DV` until `i_Tx_Done` falls; then requester 0 is served normally.
- Withhold `i_Tx_Active` (stubbed transmitter) → arbiter holds in s_WAIT_ACTIVE with `o_Busy=1`, with no further ack or DV.
